// File: rtl/sram_controller_if.sv
// Mem-stage data port between the pipeline and the SRAM bridge.
// The pipeline side is the master; the controller side is the slave.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges 32-bit Mem-stage loads/stores onto a 16-bit async SRAM as two halfword
// accesses of HALF_CYCLES clocks each; ready stays low to freeze the pipeline.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned HALF_CYCLES = 3,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned CW = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-2:0] w_q, w_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_c;
  logic               last_c;
  logic               hi_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      w_q     <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      w_q     <= w_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    w_d        = w_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    ready_c    = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    last_c     = (cnt_q == CW'(HALF_CYCLES - 1));
    hi_c       = (state_q == HIGH);

    unique case (state_q)
      IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          wr_d    = bus.wr_en;
          // Rebase then drop the byte offset; wraps modulo 2^32 below BASE_ADDR.
          w_d     = (SRAM_AW-1)'((bus.address - BASE_ADDR) >> 2);
          data_d  = bus.write_data;
          cnt_d   = '0;
          state_d = LOW;
        end else begin
          ready_c = 1'b1;
        end
      end

      LOW, HIGH: begin
        sram_addr = {w_q, hi_c};
        if (wr_q) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = hi_c ? data_q[31:16] : data_q[15:0];
          // Final cycle of each half releases WE while address/data are still held.
          sram_we_n  = last_c;
        end else begin
          sram_oe_n = 1'b0;
          if (last_c) begin
            if (hi_c) rdata_d[31:16] = sram_dq_i;
            else      rdata_d[15:0]  = sram_dq_i;
          end
        end
        if (last_c) begin
          cnt_d   = '0;
          state_d = hi_c ? DONE : HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = ready_c;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller: a word-level reference memory
// predicts load results while a halfword SRAM model checks what lands on the bus.
module tb_sram_controller;

  localparam int unsigned HC   = 3;
  localparam int unsigned AW   = 18;
  localparam int unsigned BASE = 1024;
  localparam int unsigned LAT  = 2 * HC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o;
  logic [15:0]   sram_dq_i;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;

  always #5 clk = ~clk;

  sram_controller_if bus ();

  sram_controller #(
    .BASE_ADDR  (BASE),
    .HALF_CYCLES(HC),
    .SRAM_AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Async SRAM: a write commits when WE has been low and the bus is still driven
  // during the hold cycle; a reset before that loses the write.
  logic [15:0] sram_mem [logic [AW-1:0]];
  logic        pend = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) pend = 1'b0;
    else if (!sram_we_n) pend = 1'b1;
    else if (pend && sram_dq_oe) begin
      sram_mem[sram_addr] = sram_dq_o;
      pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!sram_oe_n) sram_dq_i = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 16'h0000;
    else            sram_dq_i = 16'hFFFF;
  end

  function automatic logic [31:0] sram_peek(input logic [AW-1:0] a);
    return sram_mem.exists(a) ? {16'h0000, sram_mem[a]} : 32'h0;
  endfunction

  // Reference model: one 32-bit word per (address - BASE)/4, modulo SRAM word count.
  logic [31:0] ref_mem [logic [AW-2:0]];
  logic [31:0] ref_rd = 32'h0;
  logic [31:0] exp_q [$];

  function automatic logic [AW-2:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return (AW-1)'((off / 4) % (32'd1 << (AW - 1)));
  endfunction

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles at %0t", $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input bit drop);
    logic [AW-2:0] wi;
    wi = widx(a);
    if (wr) ref_mem[wi] = d;
    else if (rd) ref_rd = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    exp_q.push_back(ref_rd);
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = a;
    bus.write_data = d;
    if (drop) begin
      @(posedge clk);
      #1;
      bus.wr_en      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.address    = $urandom;
      bus.write_data = $urandom;
    end
    wait_ready();
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  int low_cnt = 0;

  always @(negedge clk) begin
    if (rst) low_cnt = 0;
    else begin
      check("bus_contention", {31'b0, sram_dq_oe & ~sram_oe_n}, 32'h0);
      if (!bus.ready) low_cnt++;
      else if (low_cnt > 0) begin
        check("latency", 32'(low_cnt), 32'(LAT));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: got completion expected none pending at %0t", $time);
        end else begin
          check("read_data", bus.read_data, exp_q.pop_front());
        end
        low_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        wr, rd;
    int unsigned r, gap;

    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_o",      {16'h0, sram_dq_o}, 32'h0);
    check("rst_strobes",   {29'b0, sram_dq_oe, sram_we_n, sram_oe_n}, 32'h3);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {28'b0, bus.ready, sram_we_n, sram_oe_n, sram_dq_oe}, 32'hE);
    end

    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    check("store_lo", sram_peek(18'd0), 32'h0000BEEF);
    check("store_hi", sram_peek(18'd1), 32'h0000DEAD);

    issue(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("read_hold", bus.read_data, ref_rd);

    issue(1'b1, 1'b0, 32'd1036, 32'h12345678, 1'b0);
    check("map_lo", sram_peek(18'd6), 32'h00005678);
    check("map_hi", sram_peek(18'd7), 32'h00001234);
    issue(1'b0, 1'b1, 32'd1038, 32'h0, 1'b0);

    // Abort a store during HIGH cnt=1: low half already committed, high half lost.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(sram_addr), 32'd9);
    check("pre_rst_we_n", {31'b0, sram_we_n}, 32'h0);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    ref_mem[widx(32'd1040)] = 32'h0000F00D;
    ref_rd    = 32'h0;
    #1;
    check("abort_read_data", bus.read_data, 32'h0);
    check("abort_sram_addr", 32'(sram_addr), 32'h0);
    check("abort_strobes",   {29'b0, sram_dq_oe, sram_we_n, sram_oe_n}, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, bus.ready}, 32'h1);
    check("abort_lo", sram_peek(18'd8), 32'h0000F00D);
    check("abort_hi", sram_peek(18'd9), 32'h0);
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);

    issue(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 1'b0);
    check("both_lo", sram_peek(18'd2), 32'h00005A5A);
    check("both_hi", sram_peek(18'd3), 32'h0000A5A5);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      wr = (r < 4);
      rd = (r >= 4) || (r == 0);
      if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else                           a = 32'(BASE) + 32'($urandom_range(0, 127));
      issue(wr, rd, a, $urandom, ($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
